// File: rtl/countdown_timer_pkg.sv
// Shared types and constants for the MM:SS countdown timer controller.
package countdown_timer_pkg;

  localparam int unsigned DIGIT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_ALARM = 2'd3
  } state_e;

  localparam logic [DIGIT_W-1:0] SEC_TENS_MAX = 4'd5;
  localparam logic [DIGIT_W-1:0] DIGIT_MAX    = 4'd9;

  typedef struct packed {
    logic [DIGIT_W-1:0] m1;
    logic [DIGIT_W-1:0] m0;
    logic [DIGIT_W-1:0] s1;
    logic [DIGIT_W-1:0] s0;
  } bcd_time_t;

  function automatic logic is_zero(input bcd_time_t t);
    return t == '0;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides MCLK down to a one-cycle TICK every TICK_DIV cycles; HALF is high
// during the first half of each period and drives the blinking colon.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 25175000
) (
  input  logic MCLK,
  input  logic RST,
  input  logic CLR,
  input  logic EN,
  output logic TICK,
  output logic HALF
);

  localparam int unsigned     CNT_W    = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(TICK_DIV / 2);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign TICK = (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (CLR || !EN || TICK) begin
      cnt_d = '0;
    end
  end

  // HALF is registered from the next count so it always matches cnt_q.
  always_ff @(posedge MCLK or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
      HALF  <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      HALF  <= (cnt_d < CNT_HALF);
    end
  end

endmodule

// File: rtl/countdown_timer_ctrl.sv
// MM:SS countdown timer sequencer: button press detection, BCD digits and the
// IDLE/RUN/PAUSE/ALARM state machine. COUNTDOWN_TIMER_CTRL_RELOAD_EN adds a preset reload.
module countdown_timer_ctrl
  import countdown_timer_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 25175000,
  parameter int unsigned ALARM_SECS = 5
) (
  input  logic                MCLK,
  input  logic                RST,
  input  logic                BTN_START,
  input  logic                BTN_FIELD,
  input  logic                BTN_UP,
  input  logic                BTN_CLEAR,
  output logic [DIGIT_W-1:0]  DIG_M1,
  output logic [DIGIT_W-1:0]  DIG_M0,
  output logic [DIGIT_W-1:0]  DIG_S1,
  output logic [DIGIT_W-1:0]  DIG_S0,
  output logic [1:0]          STATE,
  output logic                SEL_MIN,
  output logic                COLON,
  output logic                ALARM
);

  localparam logic [3:0] ALARM_LAST = 4'(ALARM_SECS - 1);

  state_e     state_q, state_d;
  bcd_time_t  time_q, time_d, time_inc, time_dec, reload;
  logic       sel_min_q, sel_min_d;
  logic       alarm_q;
  logic [3:0] alarm_cnt_q, alarm_cnt_d;
  logic [3:0] held_q, btn_down, press;
  logic       pr_clear, pr_start, pr_field, pr_up;
  logic       tick, half, pre_en, pre_clr;

  // History resets to "held" so a button already down when reset releases is not a press.
  assign btn_down = ~{BTN_CLEAR, BTN_START, BTN_FIELD, BTN_UP};
  assign press    = btn_down & ~held_q;

  assign pr_clear = press[3];
  assign pr_start = press[2] & ~press[3];
  assign pr_field = press[1] & ~|press[3:2];
  assign pr_up    = press[0] & ~|press[3:1];

`ifdef COUNTDOWN_TIMER_CTRL_RELOAD_EN
  bcd_time_t preset_q, preset_d;
  assign reload = preset_q;

  always_ff @(posedge MCLK or posedge RST) begin
    if (RST) preset_q <= '0;
    else     preset_q <= preset_d;
  end
`else
  assign reload = '0;
`endif

  // Increment of the selected field; no carry between fields.
  always_comb begin
    time_inc = time_q;
    if (sel_min_q) begin
      if (time_q.m0 == DIGIT_MAX) begin
        time_inc.m0 = '0;
        time_inc.m1 = (time_q.m1 == DIGIT_MAX) ? '0 : time_q.m1 + 4'd1;
      end else begin
        time_inc.m0 = time_q.m0 + 4'd1;
      end
    end else begin
      if (time_q.s0 == DIGIT_MAX) begin
        time_inc.s0 = '0;
        time_inc.s1 = (time_q.s1 == SEC_TENS_MAX) ? '0 : time_q.s1 + 4'd1;
      end else begin
        time_inc.s0 = time_q.s0 + 4'd1;
      end
    end
  end

  // One-second BCD decrement with borrow across all four digits.
  always_comb begin
    time_dec = time_q;
    if (time_q.s0 != '0) begin
      time_dec.s0 = time_q.s0 - 4'd1;
    end else begin
      time_dec.s0 = DIGIT_MAX;
      if (time_q.s1 != '0) begin
        time_dec.s1 = time_q.s1 - 4'd1;
      end else begin
        time_dec.s1 = SEC_TENS_MAX;
        if (time_q.m0 != '0) begin
          time_dec.m0 = time_q.m0 - 4'd1;
        end else begin
          time_dec.m0 = DIGIT_MAX;
          time_dec.m1 = time_q.m1 - 4'd1;
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    time_d      = time_q;
    sel_min_d   = sel_min_q;
    alarm_cnt_d = alarm_cnt_q;
`ifdef COUNTDOWN_TIMER_CTRL_RELOAD_EN
    preset_d    = preset_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pr_clear) begin
          time_d = '0;
`ifdef COUNTDOWN_TIMER_CTRL_RELOAD_EN
          preset_d = '0;
`endif
        end else if (pr_start) begin
          if (!is_zero(time_q)) begin
            state_d = ST_RUN;
`ifdef COUNTDOWN_TIMER_CTRL_RELOAD_EN
            preset_d = time_q;
`endif
          end
        end else if (pr_field) begin
          sel_min_d = ~sel_min_q;
        end else if (pr_up) begin
          time_d = time_inc;
        end
      end
      ST_RUN: begin
        if (pr_clear) begin
          state_d = ST_IDLE;
          time_d  = reload;
        end else if (pr_start) begin
          state_d = ST_PAUSE;
        end else if (tick) begin
          time_d = time_dec;
          if (is_zero(time_dec)) state_d = ST_ALARM;
        end
      end
      ST_PAUSE: begin
        if (pr_clear) begin
          state_d = ST_IDLE;
          time_d  = reload;
        end else if (pr_start) begin
          state_d = ST_RUN;
        end
      end
      ST_ALARM: begin
        if ((|press) || (tick && (alarm_cnt_q == ALARM_LAST))) begin
          state_d     = ST_IDLE;
          time_d      = reload;
          alarm_cnt_d = '0;
        end else if (tick) begin
          alarm_cnt_d = alarm_cnt_q + 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Prescaler follows the next state so it is already zero in the first IDLE/PAUSE cycle.
  assign pre_en  = (state_d == ST_RUN) || (state_d == ST_ALARM);
  assign pre_clr = pre_en && (state_d != state_q);

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .MCLK (MCLK),
    .RST  (RST),
    .CLR  (pre_clr),
    .EN   (pre_en),
    .TICK (tick),
    .HALF (half)
  );

  always_ff @(posedge MCLK or posedge RST) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      time_q      <= '0;
      sel_min_q   <= 1'b0;
      alarm_q     <= 1'b0;
      alarm_cnt_q <= '0;
      held_q      <= '1;
    end else begin
      state_q     <= state_d;
      time_q      <= time_d;
      sel_min_q   <= sel_min_d;
      alarm_q     <= (state_d == ST_ALARM);
      alarm_cnt_q <= alarm_cnt_d;
      held_q      <= btn_down;
    end
  end

  assign STATE   = state_q;
  assign DIG_M1  = time_q.m1;
  assign DIG_M0  = time_q.m0;
  assign DIG_S1  = time_q.s1;
  assign DIG_S0  = time_q.s0;
  assign SEL_MIN = sel_min_q;
  assign ALARM   = alarm_q;
  assign COLON   = (state_q == ST_RUN) ? half : (state_q == ST_IDLE);

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// Bench for countdown_timer_ctrl: directed scenarios plus random button traffic,
// all checked cycle by cycle against a seconds-based reference model.
module tb_countdown_timer_ctrl;

  localparam int unsigned TD = 10;
  localparam int unsigned AS = 3;
`ifdef COUNTDOWN_TIMER_CTRL_RELOAD_EN
  localparam bit RELOAD = 1'b1;
`else
  localparam bit RELOAD = 1'b0;
`endif
  localparam int B_UP = 0, B_FIELD = 1, B_START = 2, B_CLEAR = 3;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_ALARM = 3;

  logic       mclk = 1'b0;
  logic       rst;
  logic       btn_start, btn_field, btn_up, btn_clear;
  logic [3:0] dig_m1, dig_m0, dig_s1, dig_s0;
  logic [1:0] state;
  logic       sel_min, colon, alarm;
  logic [31:0] obs;

  always #5 mclk = ~mclk;

  countdown_timer_ctrl #(.TICK_DIV(TD), .ALARM_SECS(AS)) dut (
    .MCLK(mclk), .RST(rst),
    .BTN_START(btn_start), .BTN_FIELD(btn_field), .BTN_UP(btn_up), .BTN_CLEAR(btn_clear),
    .DIG_M1(dig_m1), .DIG_M0(dig_m0), .DIG_S1(dig_s1), .DIG_S0(dig_s0),
    .STATE(state), .SEL_MIN(sel_min), .COLON(colon), .ALARM(alarm)
  );

  assign obs = {11'd0, dig_m1, dig_m0, dig_s1, dig_s0, state, sel_min, colon, alarm};

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: time held as minutes/seconds integers, prescaler as a phase count.
  int         m_state, m_min, m_sec, m_phase, m_acnt, p_tot;
  logic       m_sel;
  logic [3:0] m_rel;
  logic [3:0] btn_lvl;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  function automatic logic [31:0] mk(input logic [15:0] dig, input logic [1:0] st,
                                     input logic sel, input logic col, input logic al);
    return {11'd0, dig, st, sel, col, al};
  endfunction

  function automatic logic [31:0] digs();
    return 32'(obs[20:5]);
  endfunction

  function automatic logic [31:0] model_out();
    logic [15:0] d;
    logic        col;
    d = {4'(m_min / 10), 4'(m_min % 10), 4'(m_sec / 10), 4'(m_sec % 10)};
    col = (m_state == M_RUN) ? (m_phase < int'(TD / 2)) : (m_state == M_IDLE);
    return mk(d, 2'(m_state), m_sel, col, m_state == M_ALARM);
  endfunction

  task automatic model_reset();
    m_state = M_IDLE; m_min = 0; m_sec = 0; m_phase = 0; m_acnt = 0; p_tot = 0;
    m_sel = 1'b0; m_rel = 4'b0000;
  endtask

  task automatic set_time(input int tot);
    m_min = tot / 60;
    m_sec = tot % 60;
  endtask

  task automatic model_edge(input logic [3:0] b);
    logic [3:0] pr;
    logic       tick;
    int         w, ns, tot, rl;
    pr = m_rel & ~b;
    m_rel = b;
    tick = ((m_state == M_RUN) || (m_state == M_ALARM)) && (m_phase == int'(TD) - 1);
    w = -1;
    if (pr[B_CLEAR]) w = B_CLEAR;
    else if (pr[B_START]) w = B_START;
    else if (pr[B_FIELD]) w = B_FIELD;
    else if (pr[B_UP]) w = B_UP;
    tot = m_min * 60 + m_sec;
    rl  = RELOAD ? p_tot : 0;
    ns  = m_state;
    case (m_state)
      M_IDLE: begin
        if (w == B_CLEAR) begin
          set_time(0); p_tot = 0;
        end else if (w == B_START) begin
          if (tot != 0) begin ns = M_RUN; p_tot = tot; end
        end else if (w == B_FIELD) begin
          m_sel = ~m_sel;
        end else if (w == B_UP) begin
          if (m_sel) m_min = (m_min + 1) % 100;
          else       m_sec = (m_sec + 1) % 60;
        end
      end
      M_RUN: begin
        if (w == B_CLEAR) begin ns = M_IDLE; set_time(rl); end
        else if (w == B_START) ns = M_PAUSE;
        else if (tick) begin
          set_time(tot - 1);
          if (tot - 1 == 0) ns = M_ALARM;
        end
      end
      M_PAUSE: begin
        if (w == B_CLEAR) begin ns = M_IDLE; set_time(rl); end
        else if (w == B_START) ns = M_RUN;
      end
      default: begin
        if (w >= 0) begin
          ns = M_IDLE; set_time(rl); m_acnt = 0;
        end else if (tick) begin
          m_acnt++;
          if (m_acnt == int'(AS)) begin ns = M_IDLE; set_time(rl); m_acnt = 0; end
        end
      end
    endcase
    if (((ns == M_RUN) || (ns == M_ALARM)) && (ns == m_state)) m_phase = tick ? 0 : m_phase + 1;
    else m_phase = 0;
    m_state = ns;
  endtask

  task automatic step(input logic [3:0] b);
    btn_lvl = b;
    {btn_clear, btn_start, btn_field, btn_up} = b;
    @(posedge mclk);
    model_edge(b);
    #1;
    check("cycle", obs, model_out());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(4'hF);
  endtask

  task automatic press(input int idx);
    logic [3:0] b;
    b = 4'hF;
    b[idx] = 1'b0;
    step(b);
    step(4'hF);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [3:0] b;
    rst = 1'b1;
    {btn_clear, btn_start, btn_field, btn_up} = 4'hF;
    btn_lvl = 4'hF;
    model_reset();
    repeat (3) @(posedge mclk);
    #1;
    check("reset", obs, mk(16'h0000, 2'd0, 1'b0, 1'b1, 1'b0));
    rst = 1'b0;
    idle(2);

    // Field select and increments with wrap
    press(B_FIELD);
    repeat (3) press(B_UP);
    check("sel_min", 32'(sel_min), 32'd1);
    check("min_up3", digs(), 32'h0300);
    press(B_FIELD);
    repeat (59) press(B_UP);
    check("sec_59", digs(), 32'h0359);
    press(B_UP);
    check("sec_wrap", digs(), 32'h0300);

    // 01:00 countdown to alarm
    press(B_CLEAR);
    press(B_FIELD);
    press(B_UP);
    check("preset_0100", digs(), 32'h0100);
    step(4'b1011);
    check("start_run", 32'(state), 32'd1);
    idle(int'(TD) - 1);
    check("before_tick", digs(), 32'h0100);
    idle(1);
    check("first_dec", digs(), 32'h0059);
    idle(59 * int'(TD) - 1);
    check("last_sec", digs(), 32'h0001);
    idle(1);
    check("to_alarm", obs, mk(16'h0000, 2'd3, 1'b1, 1'b0, 1'b1));

    // Alarm timeout
    idle(int'(AS * TD) - 1);
    check("alarm_hold", 32'(state), 32'd3);
    idle(1);
    check("alarm_timeout", 32'({state, alarm}), 32'({2'd0, 1'b0}));

    // Alarm cut short by a button
    press(B_CLEAR);
    press(B_FIELD);
    press(B_UP);
    step(4'b1011);
    idle(int'(TD));
    check("alarm_again", 32'(state), 32'd3);
    idle(2);
    step(4'b1110);
    check("alarm_btn_exit", 32'({state, alarm}), 32'({2'd0, 1'b0}));
    step(4'hF);

    // Pause and clear on a tick edge
    press(B_CLEAR);
    repeat (5) press(B_UP);
    step(4'b1011);
    step(4'hF);
    step(4'b1011);
    check("pause", 32'(state), 32'd2);
    idle(50);
    check("pause_frozen", digs(), 32'h0005);
    step(4'b1011);
    check("resume", 32'(state), 32'd1);
    idle(int'(TD) - 1);
    step(4'b0111);
    check("clear_on_tick", 32'(state), 32'd0);
    check("clear_digits", digs(), RELOAD ? 32'h0005 : 32'h0000);
    step(4'hF);

    // START and CLEAR together in IDLE, then START at 00:00
    press(B_CLEAR);
    press(B_FIELD);
    repeat (2) press(B_UP);
    check("set_0200", digs(), 32'h0200);
    step(4'b0011);
    check("start_clear", 32'({digs()[15:0], state}), 32'({16'h0000, 2'd0}));
    step(4'hF);
    press(B_START);
    check("start_zero", 32'(state), 32'd0);

    // UP held low across reset release
    step(4'b1110);
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge mclk);
    #1;
    rst = 1'b0;
    repeat (3) step(4'b1110);
    check("held_thru_rst", digs(), 32'h0000);
    step(4'hF);

    // Reset asserted mid-RUN
    repeat (3) press(B_UP);
    step(4'b1011);
    idle(4);
    check("mid_run", 32'(state), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_async", obs, mk(16'h0000, 2'd0, 1'b0, 1'b1, 1'b0));
    model_reset();
    @(posedge mclk);
    #1;
    rst = 1'b0;
    {btn_clear, btn_start, btn_field, btn_up} = 4'hF;
    idle(2);

    // Random button traffic
    for (int i = 0; i < 3000; i++) begin
      b = btn_lvl;
      if ($urandom_range(63) == 0) b[B_CLEAR] = ~b[B_CLEAR];
      if ($urandom_range(23) == 0) b[B_START] = ~b[B_START];
      if ($urandom_range(15) == 0) b[B_FIELD] = ~b[B_FIELD];
      if ($urandom_range(5) == 0)  b[B_UP]    = ~b[B_UP];
      step(b);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/countdown_timer_ctrl.md
Name: countdown_timer_ctrl

Overview:
- Sequencing controller for the board's MM:SS countdown timer.
- Takes the four debounced, active-low push-button levels and detects presses.
- Holds four BCD digit registers, generates the 1 s tick from MCLK, and runs the IDLE/RUN/PAUSE/ALARM state machine.
- Drives the digit values to external bcd_to_7seg decoders on DISP1..DISP4, plus the alarm and colon status lines.

Parameters:
- TICK_DIV, 25175000: MCLK cycles per 1 s tick. Legal range 2..2^25.
- ALARM_SECS, 5: number of ticks the ALARM state lasts before it auto-returns to IDLE. Legal range 1..15.

Ports:
- MCLK  input  1  main clock; all state changes on its rising edge.
- RST  input  1  asynchronous, active-high reset.
- BTN_START  input  1  debounced level, 0 = pressed; start/stop.
- BTN_FIELD  input  1  debounced level, 0 = pressed; toggles the selected field.
- BTN_UP  input  1  debounced level, 0 = pressed; increments the selected field.
- BTN_CLEAR  input  1  debounced level, 0 = pressed; clear.
- DIG_M1, DIG_M0, DIG_S1, DIG_S0  output  4 each  BCD digits: minutes tens, minutes units, seconds tens, seconds units.
- STATE  output  2  current state: IDLE=0, RUN=1, PAUSE=2, ALARM=3.
- SEL_MIN  output  1  1 = minutes field selected for editing, 0 = seconds.
- COLON  output  1  colon decimal-point drive, active-high.
- ALARM  output  1  high throughout the ALARM state.

Behaviour:
- Reset values: state IDLE; all digits 0; SEL_MIN=0; ALARM=0; COLON=1; prescaler=0; alarm count=0; all button-history registers=1. A button held low through reset therefore produces no press.
- Press detection:
  - press_x = prev_x & ~BTN_x, with prev_x registered every cycle.
  - The action takes effect on the first rising edge that samples the low level. Latency is 1 edge, single-shot per press.
  - Inputs are already synchronous (debouncer outputs).
- Priority: at most one button acts per cycle, in the order CLEAR > START > FIELD > UP.
- Tick:
  - The prescaler counts 0..TICK_DIV-1 and wraps; tick is asserted when count == TICK_DIV-1.
  - The prescaler runs only in RUN and ALARM. It is forced to 0 in IDLE and PAUSE and on every transition into RUN or ALARM.
  - Consequently, the first decrement after START occurs exactly TICK_DIV cycles after the START edge.
- IDLE:
  - UP increments the selected field. Seconds count 00..59 and wrap to 00; minutes count 00..99 and wrap to 00. No carry between fields.
  - FIELD toggles SEL_MIN.
  - START moves to RUN if the time is nonzero; START at 00:00 is ignored.
  - CLEAR sets the time to 00:00.
- RUN:
  - On tick, decrement the time by 1 s using BCD borrow. S0 goes 0→9 borrowing from S1; S1 goes 0→5 borrowing from M0; M0 goes 0→9 borrowing from M1.
  - If the decrement produces 00:00, move to ALARM on that same edge.
  - START moves to PAUSE. CLEAR moves to IDLE with 00:00. FIELD and UP are ignored.
  - When tick coincides with START or CLEAR, the button wins and no decrement occurs.
- PAUSE: digits frozen. START moves to RUN; CLEAR moves to IDLE with 00:00; FIELD and UP are ignored.
- ALARM:
  - ALARM=1; digits read 00:00.
  - Each tick increments the alarm count.
  - Return to IDLE on the tick that makes the count reach ALARM_SECS, or on any button press, whichever occurs first. The alarm count is cleared on exit.
- COLON:
  - In RUN: 1 while prescaler < TICK_DIV/2, else 0 (1 Hz blink).
  - In PAUSE and ALARM: 0.
  - In IDLE: 1.
- Reset mid-operation: all state returns to reset values immediately, with no pending tick or press carried over.

Optional Feature:
- Macro: COUNTDOWN_TIMER_CTRL_RELOAD_EN.
- When defined:
  - A 16-bit preset register (reset value 0000) latches the digits on the IDLE→RUN transition.
  - CLEAR in RUN or PAUSE and every exit from ALARM load the preset into the digits.
  - CLEAR in IDLE loads 00:00 into both the digits and the preset.
- When undefined: no preset register exists, and all of the above cases load 00:00.

Decomposition:
- Shared package countdown_timer_pkg contains:
  - state encoding constants ST_IDLE, ST_RUN, ST_PAUSE, ST_ALARM;
  - BCD limits SEC_TENS_MAX=5, DIGIT_MAX=9.
- One sub-module, tick_prescaler (parameter TICK_DIV; ports MCLK, RST, CLR, EN, TICK, HALF), instantiated once. HALF drives COLON.
- The BCD increment and decrement stay inline in the controller.

Test Plan (bench overrides TICK_DIV=10, ALARM_SECS=3):
- Reset, FIELD press, then 3 UP presses → SEL_MIN=1, digits 03:00. Then FIELD, 59 UP presses → 03:59; one more UP → 03:00.
- Preset 01:00, START → STATE=1. First decrement 10 cycles after the START edge gives 00:59; after 60 ticks, 00:00, STATE=3, ALARM=1.
- ALARM with no press → exactly 30 cycles later STATE=0 and ALARM=0. Repeat with an UP press 2 cycles into ALARM → STATE=0 on the next edge.
- RUN at 00:05: START → PAUSE; hold 50 cycles → digits still 00:05; START → RUN; CLEAR on the same edge as a tick → STATE=0, 00:00 (with RELOAD_EN: 00:05).
- START and CLEAR pressed on the same edge in IDLE at 02:00 → 00:00 and STATE=0. START at 00:00 → STATE stays 0.
- BTN_UP held low across RST deassertion → no increment. Assert RST mid-RUN → all outputs at reset values within the same cycle.
